// File: rtl/tmr_result_piso_if.sv
// rtl/tmr_result_piso_if.sv - load/data/status bundle between the TMR voters, the PISO and the serial pin
interface tmr_result_piso_if #(
    parameter int RES_W = 16,
    parameter int MUL_W = 15
);
    logic             LOAD;
    logic [RES_W-1:0] RES_IN;
    logic [MUL_W-1:0] MUL_IN;
    logic             COUT_IN;
    logic             CLR_OVR;
    logic             SO_DATA;
    logic             SO_VALID;
    logic             BUSY;
    logic             DONE;
    logic             OVERRUN;

    modport master (
        output LOAD, RES_IN, MUL_IN, COUT_IN, CLR_OVR,
        input  SO_DATA, SO_VALID, BUSY, DONE, OVERRUN
    );

    modport slave (
        input  LOAD, RES_IN, MUL_IN, COUT_IN, CLR_OVR,
        output SO_DATA, SO_VALID, BUSY, DONE, OVERRUN
    );
endinterface

// File: rtl/tmr_result_piso.sv
// rtl/tmr_result_piso.sv - voted result PISO, LSB-first 32-bit frame; TMR_PISO_PARITY_EN appends even parity
module tmr_result_piso #(
    parameter int RES_W = 16,
    parameter int MUL_W = 15
) (
    input  logic             CLK,
    input  logic             RST,
    tmr_result_piso_if.slave bus
);
    localparam int FRAME_W = RES_W + MUL_W + 1;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef TMR_PISO_PARITY_EN
        S_PAR   = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [FRAME_W-1:0]   shreg;
    logic [CNT_W-1:0]     cnt;
    logic                 so_data_q;
    logic                 so_valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 overrun_q;
`ifdef TMR_PISO_PARITY_EN
    logic                 par_q;
`endif

    logic [FRAME_W-1:0] frame_in;
    assign frame_in = {bus.COUT_IN, bus.MUL_IN, bus.RES_IN};

    // Outputs are registered one step ahead of the state, so bit 0 is on the
    // pin in the cycle right after the capturing edge and DONE coincides with S_DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            so_data_q  <= 1'b0;
            so_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef TMR_PISO_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            if (bus.LOAD && busy_q) begin
                overrun_q <= 1'b1;
            end else if (bus.CLR_OVR) begin
                overrun_q <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.LOAD) begin
                        shreg      <= frame_in >> 1;
                        so_data_q  <= frame_in[0];
                        so_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        cnt        <= '0;
                        state      <= S_SHIFT;
`ifdef TMR_PISO_PARITY_EN
                        par_q      <= ^frame_in;
`endif
                    end else begin
                        so_data_q  <= 1'b0;
                        so_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    if (cnt == LAST_BIT) begin
`ifdef TMR_PISO_PARITY_EN
                        so_data_q  <= par_q;
                        so_valid_q <= 1'b1;
                        state      <= S_PAR;
`else
                        so_data_q  <= 1'b0;
                        so_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= S_DONE;
`endif
                    end else begin
                        so_data_q <= shreg[0];
                        shreg     <= shreg >> 1;
                        cnt       <= cnt + 1'b1;
                    end
                end

`ifdef TMR_PISO_PARITY_EN
                S_PAR: begin
                    so_data_q  <= 1'b0;
                    so_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state      <= S_DONE;
                end
`endif

                default: begin
                    so_data_q  <= 1'b0;
                    so_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.SO_DATA  = so_data_q;
    assign bus.SO_VALID = so_valid_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.OVERRUN  = overrun_q;
endmodule

// File: tb/tb_tmr_result_piso.sv
// tb/tb_tmr_result_piso.sv - table vectors, corner sequences and random traffic against a cycle schedule model
module tb_tmr_result_piso;
`ifdef TMR_PISO_PARITY_EN
    localparam int FLEN = 33;
`else
    localparam int FLEN = 32;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    tmr_result_piso_if #(.RES_W(16), .MUL_W(15)) bus ();
    tmr_result_piso #(.RES_W(16), .MUL_W(15)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct packed {
        logic v;
        logic d;
        logic b;
        logic dn;
    } cyc_t;

    typedef struct {
        logic [15:0] r;
        logic [14:0] m;
        logic        c;
        logic [31:0] w;
        logic        p;
    } vec_t;

    cyc_t   cur;
    cyc_t   sched[$];
    logic   m_ovr;
    logic   rx[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    vec_t   tbl[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Reference: each accepted LOAD appends one expected record per future cycle.
    task automatic tick();
        logic [31:0] w;
        int          ones;
        @(posedge CLK);
        if (RST) begin
            sched.delete();
            m_ovr = 1'b0;
            cur   = '0;
        end else begin
            if (bus.LOAD && cur.b) m_ovr = 1'b1;
            else if (bus.CLR_OVR) m_ovr = 1'b0;
            if (bus.LOAD && !cur.b) begin
                w = 32'(bus.RES_IN) + (32'(bus.MUL_IN) << 16) + (32'(bus.COUT_IN) << 31);
                ones = 0;
                for (int i = 0; i < 32; i++) begin
                    sched.push_back('{v: 1'b1, d: w[i], b: 1'b1, dn: 1'b0});
                    ones += int'(w[i]);
                end
`ifdef TMR_PISO_PARITY_EN
                sched.push_back('{v: 1'b1, d: ones[0], b: 1'b1, dn: 1'b0});
`endif
                sched.push_back('{v: 1'b0, d: 1'b0, b: 1'b0, dn: 1'b1});
            end
            cur = (sched.size() > 0) ? sched.pop_front() : '0;
        end
        #1;
        cyc++;
        chk("cycle_outputs", {27'd0, bus.SO_VALID, bus.SO_DATA, bus.BUSY, bus.DONE, bus.OVERRUN},
            {27'd0, cur.v, cur.d, cur.b, cur.dn, m_ovr});
        if (bus.SO_VALID) rx.push_back(bus.SO_DATA);
    endtask

    task automatic set_in(input logic [15:0] r, input logic [14:0] m, input logic c);
        bus.RES_IN  = r;
        bus.MUL_IN  = m;
        bus.COUT_IN = c;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.DONE && n < 40) begin
            tick();
            n++;
        end
        chk("done_seen", {31'd0, bus.DONE}, 32'd1);
    endtask

    function automatic logic [31:0] rx_word();
        logic [31:0] w = '0;
        for (int i = 0; i < 32 && i < rx.size(); i++) w[i] = rx[i];
        return w;
    endfunction

    task automatic run_frame(input vec_t t, input string name);
        int n;
        rx.delete();
        set_in(t.r, t.m, t.c);
        bus.LOAD = 1'b1;
        tick();
        bus.LOAD = 1'b0;
        wait_done(n);
        chk({name, "_word"}, rx_word(), t.w);
        chk({name, "_bits"}, 32'(rx.size()), 32'(FLEN));
        chk({name, "_done_latency"}, 32'(n + 1), 32'(FLEN + 1));
`ifdef TMR_PISO_PARITY_EN
        chk({name, "_parity"}, {31'd0, (rx.size() > 32) ? rx[32] : 1'bx}, {31'd0, t.p});
`endif
    endtask

    initial begin
        int n;
        int dn_cnt;
        tbl[0] = '{r: 16'hA5F0, m: 15'h1234, c: 1'b1, w: 32'h9234A5F0, p: 1'b0};
        tbl[1] = '{r: 16'h0001, m: 15'h0000, c: 1'b0, w: 32'h00000001, p: 1'b1};
        tbl[2] = '{r: 16'hFFFF, m: 15'h7FFF, c: 1'b1, w: 32'hFFFFFFFF, p: 1'b0};
        tbl[3] = '{r: 16'h0000, m: 15'h0000, c: 1'b0, w: 32'h00000000, p: 1'b0};
        tbl[4] = '{r: 16'h0000, m: 15'h7FFF, c: 1'b0, w: 32'h7FFF0000, p: 1'b1};
        tbl[5] = '{r: 16'h1111, m: 15'h0000, c: 1'b1, w: 32'h80001111, p: 1'b1};

        RST = 1'b1;
        bus.LOAD = 1'b0;
        bus.CLR_OVR = 1'b0;
        set_in('0, '0, 1'b0);
        cur = '0;
        m_ovr = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        chk("reset_state", {27'd0, bus.SO_VALID, bus.SO_DATA, bus.BUSY, bus.DONE, bus.OVERRUN}, 32'd0);
        tick();

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i], $sformatf("vec%0d", i));
            repeat (2) tick();
        end

        // Overrun: second LOAD at bit 10 is dropped and flagged
        rx.delete();
        set_in(16'h1111, '0, 1'b0);
        bus.LOAD = 1'b1;
        tick();
        bus.LOAD = 1'b0;
        repeat (10) tick();
        set_in(16'h2222, '0, 1'b0);
        bus.LOAD = 1'b1;
        tick();
        bus.LOAD = 1'b0;
        chk("ovr_set", {31'd0, bus.OVERRUN}, 32'd1);
        wait_done(n);
        chk("ovr_word", rx_word(), 32'h00001111);
        repeat (3) tick();
        chk("ovr_sticky", {31'd0, bus.OVERRUN}, 32'd1);
        bus.CLR_OVR = 1'b1;
        tick();
        bus.CLR_OVR = 1'b0;
        chk("ovr_clear", {31'd0, bus.OVERRUN}, 32'd0);

        // Back-to-back: LOAD during the DONE cycle
        run_frame(tbl[0], "b2b_first");
        rx.delete();
        set_in(16'hFFFF, '0, 1'b0);
        bus.LOAD = 1'b1;
        tick();
        bus.LOAD = 1'b0;
        chk("b2b_no_gap", {30'd0, bus.SO_VALID, bus.SO_DATA}, 32'd3);
        chk("b2b_no_ovr", {31'd0, bus.OVERRUN}, 32'd0);
        wait_done(n);
        chk("b2b_word", rx_word(), 32'h0000FFFF);
        tick();

        // Reset at bit 20 aborts without DONE
        set_in(tbl[2].r, tbl[2].m, tbl[2].c);
        bus.LOAD = 1'b1;
        tick();
        bus.LOAD = 1'b0;
        repeat (20) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_mid_outputs", {27'd0, bus.SO_VALID, bus.SO_DATA, bus.BUSY, bus.DONE, bus.OVERRUN}, 32'd0);
        dn_cnt = 0;
        repeat (40) begin
            tick();
            dn_cnt += int'(bus.DONE);
        end
        chk("rst_mid_no_done", 32'(dn_cnt), 32'd0);
        run_frame(tbl[0], "after_rst");

        // Idle hygiene
        dn_cnt = 0;
        repeat (100) begin
            tick();
            dn_cnt += int'(bus.SO_VALID | bus.SO_DATA | bus.DONE | bus.BUSY);
        end
        chk("idle_quiet", 32'(dn_cnt), 32'd0);

        // Random traffic against the model
        repeat (3000) begin
            RST         = ($urandom_range(0, 499) == 0);
            bus.LOAD    = ($urandom_range(0, 15) == 0);
            bus.CLR_OVR = ($urandom_range(0, 29) == 0);
            set_in(16'($urandom), 15'($urandom), 1'($urandom));
            tick();
        end
        RST = 1'b0;
        bus.LOAD = 1'b0;
        bus.CLR_OVR = 1'b0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
